// File: rtl/umc_pkg.sv
// Shared types and helpers for the unified instruction/data memory controller.
// Imported by the controller top level.
package umc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DREAD
  } state_e;

  function automatic int instr_w(input int bytes, input int w);
    return bytes * w;
  endfunction

endpackage

// File: rtl/mem_array_sp.sv
// Single-port synchronous RAM, one access per cycle, no reset.
// Read data holds its value until the next read.
module mem_array_sp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] RAM [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) RAM[addr] <= wdata;
      else    rdata     <= RAM[addr];
    end
  end

endmodule

// File: rtl/unified_mem_ctrl.sv
// Arbitrated front end sharing one single-port array between loader,
// data port and a multi-byte instruction fetch port.
module unified_mem_ctrl
  import umc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 9,
  parameter int INSTR_BYTES = 2
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    if_req,
  input  logic [ADDR_W-1:0]                       if_addr,
  output logic                                    if_ready,
  output logic                                    if_valid,
  output logic [instr_w(INSTR_BYTES, DATA_W)-1:0] if_data,
  input  logic                                    d_req,
  input  logic                                    d_we,
  input  logic [ADDR_W-1:0]                       d_addr,
  input  logic [DATA_W-1:0]                       d_wdata,
  output logic                                    d_ready,
  output logic                                    d_valid,
  output logic [DATA_W-1:0]                       d_rdata,
  input  logic                                    ld_we,
  input  logic [ADDR_W-1:0]                       ld_addr,
  input  logic [DATA_W-1:0]                       ld_wdata,
  output logic                                    busy
);

  localparam int INSTR_W = instr_w(INSTR_BYTES, DATA_W);
  localparam int K_W     = $clog2(INSTR_BYTES + 1);
  localparam logic [K_W-1:0] K_LAST = K_W'(INSTR_BYTES);

  state_e             state_q, state_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [INSTR_W-1:0] asm_q, asm_d;
  logic               if_valid_q, if_valid_d;
  logic               d_valid_q, d_valid_d;
  logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;

  logic               mem_en;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  mem_rdata;
  logic [K_W-1:0]     cap_sel;

  mem_array_sp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign cap_sel = k_q - K_W'(1);

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    base_d     = base_q;
    asm_d      = asm_q;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    d_rdata_d  = d_rdata_q;
    if_ready   = 1'b0;
    d_ready    = 1'b0;
    mem_en     = ld_we;
    mem_we     = ld_we;
    mem_addr   = ld_addr;
    mem_wdata  = ld_wdata;

    unique case (state_q)
      IDLE: begin
        if (!ld_we && rst_n) begin
          d_ready  = d_req;
          if_ready = if_req & ~d_req;
          if (d_req) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            if (!d_we) state_d = DREAD;
          end else if (if_req) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
            base_d   = if_addr;
            k_d      = K_W'(1);
            state_d  = FETCH;
          end
        end
      end
      FETCH: begin
        // Loader cycles freeze the fetch; read data stays held in the RAM.
        if (!ld_we) begin
          for (int i = 0; i < INSTR_BYTES; i++) begin
            if (cap_sel == K_W'(i))
              asm_d[i*DATA_W +: DATA_W] = mem_rdata;
          end
          if (k_q == K_LAST) begin
            state_d    = IDLE;
            if_valid_d = 1'b1;
            k_d        = '0;
          end else begin
            mem_en   = 1'b1;
            mem_addr = base_q + ADDR_W'(k_q);
            k_d      = k_q + K_W'(1);
          end
        end
      end
      DREAD: begin
        d_valid_d = 1'b1;
        d_rdata_d = mem_rdata;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      base_q     <= '0;
      asm_q      <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      base_q     <= base_d;
      asm_q      <= asm_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign if_valid = if_valid_q;
  assign if_data  = asm_q;
  assign d_valid  = d_valid_q;
  assign d_rdata  = d_rdata_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Directed plus randomized bench for unified_mem_ctrl.
// Two instances (2-byte and 4-byte instructions) share all stimulus.
module tb_unified_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       if_req;
  logic [8:0] if_addr;
  logic       d_req;
  logic       d_we;
  logic [8:0] d_addr;
  logic [7:0] d_wdata;
  logic       ld_we;
  logic [8:0] ld_addr;
  logic [7:0] ld_wdata;

  logic        if_ready, if_valid, d_ready, d_valid, busy;
  logic [15:0] if_data;
  logic [7:0]  d_rdata;
  logic        if_ready4, if_valid4, d_ready4, d_valid4, busy4;
  logic [31:0] if_data4;
  logic [7:0]  d_rdata4;

  logic [7:0] mem_m [512];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  unified_mem_ctrl #(.DATA_W(8), .ADDR_W(9), .INSTR_BYTES(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_valid(if_valid), .if_data(if_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_valid(d_valid), .d_rdata(d_rdata),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .busy(busy)
  );

  unified_mem_ctrl #(.DATA_W(8), .ADDR_W(9), .INSTR_BYTES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready4),
    .if_valid(if_valid4), .if_data(if_data4),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready4), .d_valid(d_valid4), .d_rdata(d_rdata4),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .busy(busy4)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ld_write(input logic [8:0] a, input logic [7:0] v);
    ld_we = 1'b1; ld_addr = a; ld_wdata = v;
    step();
    ld_we = 1'b0;
    mem_m[a] = v;
  endtask

  task automatic d_write(input logic [8:0] a, input logic [7:0] v);
    d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = v;
    #1;
    chk("d_ready_wr", {d_ready, d_ready4}, 2'b11);
    step();
    d_req = 1'b0; d_we = 1'b0;
    mem_m[a] = v;
    chk("busy_after_wr", {busy, busy4, d_valid}, 3'b000);
  endtask

  task automatic d_read(input logic [8:0] a);
    d_req = 1'b1; d_we = 1'b0; d_addr = a;
    #1;
    chk("d_ready_rd", {d_ready, d_ready4}, 2'b11);
    step();
    d_req = 1'b0; d_addr = 9'($urandom);
    chk("busy_dread", {busy, busy4, d_valid}, 3'b110);
    step();
    chk("d_valid", {d_valid, d_valid4, busy}, 3'b110);
    chk("d_rdata", d_rdata, mem_m[a]);
    chk("d_rdata4", d_rdata4, mem_m[a]);
    step();
    chk("d_valid_drop", {d_valid, d_valid4}, 2'b00);
  endtask

  // stall_e > 0 places one loader write in the cycle after edge stall_e-1
  task automatic fetch(input logic [8:0] a, input int stall_e,
                       input logic [8:0] la, input logic [7:0] lv);
    int e2 = -1;
    int e4 = -1;
    logic [15:0] o2 = '0;
    logic [31:0] o4 = '0;
    logic [15:0] x2;
    logic [31:0] x4;
    int extra;
    if_req = 1'b1; if_addr = a;
    #1;
    chk("if_ready", {if_ready, if_ready4, d_ready}, 3'b110);
    step();
    if_req = $urandom_range(0, 1) == 1;
    if_addr = 9'($urandom);
    for (int e = 1; e <= 12 && (e2 < 0 || e4 < 0); e++) begin
      if (e == stall_e) begin
        ld_we = 1'b1; ld_addr = la; ld_wdata = lv;
      end
      step();
      if (e == stall_e) begin
        ld_we = 1'b0;
        mem_m[la] = lv;
      end
      if (e == 1) if_req = 1'b0;
      if (if_valid && e2 < 0) begin e2 = e; o2 = if_data; end
      if (if_valid4 && e4 < 0) begin e4 = e; o4 = if_data4; end
    end
    extra = (stall_e > 0) ? 1 : 0;
    x2 = {mem_m[a + 9'd1], mem_m[a]};
    x4 = {mem_m[a + 9'd3], mem_m[a + 9'd2], mem_m[a + 9'd1], mem_m[a]};
    chk("fetch_lat2", 64'(e2), 64'(2 + extra));
    chk("fetch_lat4", 64'(e4), 64'(4 + extra));
    chk("fetch_data2", o2, x2);
    chk("fetch_data4", o4, x4);
    chk("fetch_end", {busy, busy4, if_valid}, 3'b000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    if_req = 0; if_addr = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    ld_we = 0; ld_addr = 0; ld_wdata = 0;
    repeat (2) step();
    chk("rst_outs", {if_ready, if_valid, d_ready, d_valid, busy}, 5'b0);
    chk("rst_data", {if_data, d_rdata, if_data4}, 56'b0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 512; i++) ld_write(9'(i), 8'($urandom));

    // scenario 1
    ld_write(9'd32, 8'h04);
    ld_write(9'd33, 8'h5B);
    fetch(9'd32, 0, 9'd0, 8'd0);
    chk("s1_const", {mem_m[33], mem_m[32]}, 16'h5B04);

    // scenario 2: wrap-around
    ld_write(9'd511, 8'hAA);
    ld_write(9'd0, 8'h55);
    fetch(9'd511, 0, 9'd0, 8'd0);

    // scenario 3
    d_write(9'd4, 8'h0A);
    d_read(9'd4);

    // scenario 4: data beats fetch
    if_req = 1'b1; if_addr = 9'd32;
    d_req = 1'b1; d_we = 1'b1; d_addr = 9'd8; d_wdata = 8'h77;
    #1;
    chk("s4_ready", {d_ready, if_ready}, 2'b10);
    step();
    d_req = 1'b0; d_we = 1'b0;
    mem_m[8] = 8'h77;
    fetch(9'd32, 0, 9'd0, 8'd0);
    d_read(9'd8);

    // scenario 5: loader stall on a pending byte
    fetch(9'd32, 1, 9'd33, 8'hC3);

    // scenario 6: reset mid-fetch keeps the array
    if_req = 1'b1; if_addr = 9'd32;
    step();
    if_req = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {if_ready, if_valid, busy, busy4, if_ready4}, 5'b0);
    chk("rst_mid_d", {if_data, d_rdata, if_data4, d_valid}, 57'b0);
    if_req = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("no_if_valid", {if_valid, if_valid4, d_valid}, 3'b0);
    end
    d_read(9'd32);
    chk("mem32_kept", d_rdata, 8'h04);

    for (int i = 0; i < 4; i++) ld_write(9'(32 + i), 8'(i + 1));
    fetch(9'd32, 0, 9'd0, 8'd0);
    chk("s6_const4", if_data4, 32'h04030201);

    // randomized traffic against the byte-array model
    for (int it = 0; it < 40; it++) begin
      logic [8:0] a;
      int op;
      a = 9'($urandom);
      op = $urandom_range(0, 4);
      case (op)
        0: ld_write(a, 8'($urandom));
        1: d_write(a, 8'($urandom));
        2: d_read(a);
        3: fetch(a, 0, 9'd0, 8'd0);
        default: fetch(a, 1, a + 9'($urandom_range(1, 3)),
                       8'($urandom));
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
